// File: rtl/axis2bram_pingpong_pkg.sv
// Shared types for the ping-pong stream-to-BRAM writer.
// Bank and FSM state encodings plus BRAM port constants.
package axis2bram_pkg;

  localparam int         RAM_W  = 32;
  localparam logic [3:0] WE_ALL = 4'hF;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL
  } bank_st_t;

  typedef enum logic {
    FILL,
    STALL
  } fsm_st_t;

endpackage

// File: rtl/axis2bram_pingpong_if.sv
// AXI-Stream sample channel into the ping-pong writer.
// master drives the beat, slave returns tready.
interface axis2bram_pingpong_if #(
  parameter int DATA_W = 16
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis2bram_pingpong_bank_tracker.sv
// Tracks FREE/FILLING/FULL per bank and the order in which
// full banks await release by the PS.
module axis2bram_bank_tracker
  import axis2bram_pkg::*;
(
  input  logic clk_240M,
  input  logic rst,
  input  logic act,
  input  logic start,
  input  logic close,
  input  logic ack,
  output logic other_free,
  output logic both_full,
  output logic oldest,
  output logic ack_err
);

  bank_st_t   bank [2];
  logic [1:0] cnt;
  logic       head;
  logic       pop;

  assign pop        = ack && (cnt != 2'd0);
  assign oldest     = head;
  assign both_full  = (bank[0] == FULL) && (bank[1] == FULL);
  // an ack landing this cycle counts as freeing the other bank
  assign other_free = (bank[~act] == FREE) ||
                      (pop && (head == ~act));

  always_ff @(posedge clk_240M) begin
    if (rst) begin
      bank[0] <= FREE;
      bank[1] <= FREE;
      cnt     <= 2'd0;
      head    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      if (close)
        bank[act] <= FULL;
      else if (start)
        bank[act] <= FILLING;
      if (pop)
        bank[head] <= FREE;
      cnt <= cnt + 2'(close) - 2'(pop);
      // banks close alternately, so the queue is just head + count
      if (pop)
        head <= ~head;
      else if (close && (cnt == 2'd0))
        head <= act;
      if (ack && !pop)
        ack_err <= 1'b1;
    end
  end

endmodule

// File: rtl/axis2bram_pingpong.sv
// AXI-Stream to dual-bank BRAM writer with per-bank irq to the PS
// and tready backpressure while both banks await release.
module axis2bram_pingpong
  import axis2bram_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 8,
  parameter int          SIGNED    = 0,
  parameter int          ADDR_STEP = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                         clk_240M,
  input  logic                         rst,
  axis2bram_pingpong_if.slave          s_axis,
  input  logic                         buf_ack,
  output logic                         ram_clk,
  output logic                         ram_rst,
  output logic                         ram_en,
  output logic [3:0]                   ram_we,
  output logic [31:0]                  ram_addr,
  output logic [31:0]                  ram_wr_data,
  input  logic [31:0]                  ram_rd_data,
  output logic                         ram_rd_irq,
  output logic                         done_bank,
  output logic [$clog2(DEPTH+1)-1:0]   done_len,
  output logic                         ack_err
);

  localparam int LW = $clog2(DEPTH + 1);

  fsm_st_t          state;
  logic             act;
  logic [LW-1:0]    idx;
  logic             accept;
  logic             close;
  logic             other_free;
  logic             both_full;
  logic             oldest;
  logic             cl_vld;
  logic             cl_bank;
  logic [LW-1:0]    cl_len;
  logic [RAM_W-1:0] ext;
  logic [RAM_W-1:0] addr_nx;
  logic             unused_rd;

  assign ram_clk   = clk_240M;
  assign ram_rst   = rst;
  assign unused_rd = ^ram_rd_data;

  assign accept = s_axis.tvalid && s_axis.tready;
  assign close  = accept &&
                  ((idx == LW'(DEPTH - 1)) || s_axis.tlast);

  assign ext = (SIGNED != 0) ? RAM_W'($signed(s_axis.tdata))
                             : RAM_W'(s_axis.tdata);

  assign addr_nx = BASE_ADDR +
                   (32'(act) * 32'(DEPTH) + 32'(idx)) *
                   32'(ADDR_STEP);

  axis2bram_bank_tracker u_trk (
    .clk_240M   (clk_240M),
    .rst        (rst),
    .act        (act),
    .start      (accept),
    .close      (close),
    .ack        (buf_ack),
    .other_free (other_free),
    .both_full  (both_full),
    .oldest     (oldest),
    .ack_err    (ack_err)
  );

  always_ff @(posedge clk_240M) begin
    if (rst) begin
      state         <= FILL;
      s_axis.tready <= 1'b0;
      act           <= 1'b0;
      idx           <= '0;
      ram_en        <= 1'b0;
      ram_we        <= '0;
      ram_addr      <= '0;
      ram_wr_data   <= '0;
      cl_vld        <= 1'b0;
      cl_bank       <= 1'b0;
      cl_len        <= '0;
      ram_rd_irq    <= 1'b0;
      done_bank     <= 1'b0;
      done_len      <= '0;
    end else begin
      ram_en <= accept;
      ram_we <= accept ? WE_ALL : 4'h0;
      if (accept) begin
        ram_addr    <= addr_nx;
        ram_wr_data <= ext;
      end

      if (close) begin
        act <= ~act;
        idx <= '0;
      end else if (accept) begin
        idx <= idx + LW'(1);
      end

      // irq trails the last write by one cycle
      cl_vld <= close;
      if (close) begin
        cl_bank <= act;
        cl_len  <= idx + LW'(1);
      end
      ram_rd_irq <= cl_vld;
      if (cl_vld) begin
        done_bank <= cl_bank;
        done_len  <= cl_len;
      end

      unique case (state)
        FILL: begin
          if (close && !other_free) begin
            state         <= STALL;
            s_axis.tready <= 1'b0;
          end else begin
            s_axis.tready <= 1'b1;
          end
        end
        STALL: begin
          if (buf_ack && both_full && (oldest == act)) begin
            state         <= FILL;
            s_axis.tready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
